// File: rtl/imem_uart_loader.sv
// Boot loader: parses a length-prefixed UART byte stream into little-endian 32-bit
// words for the instruction memory and holds the CPU until the image is complete.
// Optional trailing checksum byte enabled by defining IMEM_LOADER_CSUM_EN.
module imem_uart_loader #(
    parameter int DEPTH       = 30,
    parameter int TIMEOUT_CYC = 50000,
    parameter int AW          = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          rx_valid,
    input  logic [7:0]    rx_data,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [31:0]   wr_data,
    output logic          cpu_hold,
    output logic          busy,
    output logic          done,
    output logic [1:0]    err
);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_LEN  = 2'b01;
    localparam logic [1:0] ERR_TO   = 2'b10;
    localparam logic [1:0] ERR_CSUM = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE, S_LEN0, S_LEN1, S_DATA, S_CSUM, S_FIN, S_DONE, S_ERR
    } state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   tcnt_q, tcnt_d;
    logic [15:0]     len_q, len_d;
    logic [AW-1:0]   widx_q, widx_d;
    logic [1:0]      bcnt_q, bcnt_d;
    logic [23:0]     word_q, word_d;
    logic            wr_en_d;
    logic [AW-1:0]   wr_addr_d;
    logic [31:0]     wr_data_d;
    logic [1:0]      err_d;
    logic            busy_d;
    logic [15:0]     len_rx;
`ifdef IMEM_LOADER_CSUM_EN
    logic [7:0]      csum_q, csum_d;
`endif

    assign len_rx = {rx_data, len_q[7:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        tcnt_d    = tcnt_q;
        len_d     = len_q;
        widx_d    = widx_q;
        bcnt_d    = bcnt_q;
        word_d    = word_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr;
        wr_data_d = wr_data;
        err_d     = err;
`ifdef IMEM_LOADER_CSUM_EN
        csum_d    = csum_q;
`endif
        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_d = S_LEN0;
                    err_d   = ERR_NONE;
                    tcnt_d  = '0;
                    widx_d  = '0;
                    bcnt_d  = '0;
`ifdef IMEM_LOADER_CSUM_EN
                    csum_d  = '0;
`endif
                end
            end
            S_FIN: state_d = S_DONE;
            default: begin
                // An arriving byte takes priority over an expiring timeout.
                if (rx_valid) begin
                    tcnt_d = '0;
                    case (state_q)
                        S_LEN0: begin
                            len_d[7:0] = rx_data;
                            state_d    = S_LEN1;
                        end
                        S_LEN1: begin
                            len_d = len_rx;
                            if (len_rx >= 16'd1 && len_rx <= 16'(DEPTH)) begin
                                state_d = S_DATA;
                            end else begin
                                state_d = S_ERR;
                                err_d   = ERR_LEN;
                            end
                        end
                        S_DATA: begin
                            bcnt_d = bcnt_q + 2'd1;
`ifdef IMEM_LOADER_CSUM_EN
                            csum_d = csum_q + rx_data;
`endif
                            case (bcnt_q)
                                2'd0: word_d[7:0]   = rx_data;
                                2'd1: word_d[15:8]  = rx_data;
                                2'd2: word_d[23:16] = rx_data;
                                default: begin
                                    wr_en_d   = 1'b1;
                                    wr_addr_d = widx_q;
                                    wr_data_d = {rx_data, word_q};
                                    widx_d    = widx_q + AW'(1);
                                    if (16'(widx_q) == len_q - 16'd1) begin
`ifdef IMEM_LOADER_CSUM_EN
                                        state_d = S_CSUM;
`else
                                        state_d = S_FIN;
`endif
                                    end
                                end
                            endcase
                        end
`ifdef IMEM_LOADER_CSUM_EN
                        S_CSUM: begin
                            if (rx_data == csum_q) begin
                                state_d = S_FIN;
                            end else begin
                                state_d = S_ERR;
                                err_d   = ERR_CSUM;
                            end
                        end
`endif
                        default: ;
                    endcase
                end else if (tcnt_q == TW'(TIMEOUT_CYC)) begin
                    state_d = S_ERR;
                    err_d   = ERR_TO;
                end else begin
                    tcnt_d = tcnt_q + TW'(1);
                end
            end
        endcase
    end

    assign busy_d = (state_d == S_LEN0) || (state_d == S_LEN1) ||
                    (state_d == S_DATA) || (state_d == S_CSUM);

    // Outputs are registered from the next-state decode so they align with the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tcnt_q   <= '0;
            len_q    <= '0;
            widx_q   <= '0;
            bcnt_q   <= '0;
            word_q   <= '0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            err      <= ERR_NONE;
            busy     <= 1'b0;
            done     <= 1'b0;
            cpu_hold <= 1'b1;
`ifdef IMEM_LOADER_CSUM_EN
            csum_q   <= '0;
`endif
        end else begin
            tcnt_q   <= tcnt_d;
            len_q    <= len_d;
            widx_q   <= widx_d;
            bcnt_q   <= bcnt_d;
            word_q   <= word_d;
            wr_en    <= wr_en_d;
            wr_addr  <= wr_addr_d;
            wr_data  <= wr_data_d;
            err      <= err_d;
            busy     <= busy_d;
            done     <= (state_d == S_DONE);
            cpu_hold <= (state_d != S_DONE);
`ifdef IMEM_LOADER_CSUM_EN
            csum_q   <= csum_d;
`endif
        end
    end

endmodule

// File: tb/tb_imem_uart_loader.sv
// Directed self-checking bench for imem_uart_loader (short timeout for fast runs).
`timescale 1ns/1ps
module tb_imem_uart_loader;
    localparam int DEPTH = 30;
    localparam int TO    = 100;
    localparam int AW    = $clog2(DEPTH);

    logic          clk = 1'b0;
    logic          rst, start, rx_valid;
    logic [7:0]    rx_data;
    logic          wr_en, cpu_hold, busy, done;
    logic [AW-1:0] wr_addr;
    logic [31:0]   wr_data;
    logic [1:0]    err;

    int n_checks = 0;
    int n_errors = 0;

    logic [AW-1:0] wa[$];
    logic [31:0]   wd[$];

    imem_uart_loader #(.DEPTH(DEPTH), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst), .start(start), .rx_valid(rx_valid), .rx_data(rx_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .cpu_hold(cpu_hold), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (wr_en) begin
        wa.push_back(wr_addr);
        wd.push_back(wr_data);
    end

    // Drivers assume they are entered just after a falling edge.
    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1; rx_data = b;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        n_checks++; if (cpu_hold !== 1'b1) begin n_errors++; $display("FAIL rst_hold got %b exp 1", cpu_hold); end
        n_checks++; if (wr_en !== 1'b0) begin n_errors++; $display("FAIL rst_wr_en got %b exp 0", wr_en); end
        n_checks++; if (wr_addr !== '0 || wr_data !== 32'h0) begin n_errors++; $display("FAIL rst_wr got %h/%h exp 0/0", wr_addr, wr_data); end
        n_checks++; if ({busy, done, err} !== 4'b0) begin n_errors++; $display("FAIL rst_status got %b exp 0000", {busy, done, err}); end
        rst = 1'b0;
        @(negedge clk);
        wa.delete(); wd.delete();
        send_byte(8'h02); send_byte(8'h00); send_byte(8'h13); send_byte(8'h00);
        @(negedge clk);
        n_checks++; if (busy !== 1'b0 || wa.size() != 0) begin n_errors++; $display("FAIL idle_ignore busy %b writes %0d exp 0 0", busy, wa.size()); end
    endtask

    task automatic test_basic();
        logic [7:0] s [10] = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        wa.delete(); wd.delete();
        do_start();
        n_checks++; if (busy !== 1'b1 || cpu_hold !== 1'b1) begin n_errors++; $display("FAIL start_busy got %b%b exp 11", busy, cpu_hold); end
        for (int i = 0; i < 10; i++) send_byte(s[i]);
        n_checks++; if (wr_en !== 1'b1 || wr_addr !== AW'(1) || wr_data !== 32'h00100093) begin n_errors++; $display("FAIL last_write got %b %h %h exp 1 01 00100093", wr_en, wr_addr, wr_data); end
        n_checks++; if (done !== 1'b0 || busy !== 1'b0 || cpu_hold !== 1'b1) begin n_errors++; $display("FAIL fin_cycle got d%b b%b h%b exp 0 0 1", done, busy, cpu_hold); end
        @(negedge clk);
        n_checks++; if (done !== 1'b1 || cpu_hold !== 1'b0 || busy !== 1'b0 || wr_en !== 1'b0) begin n_errors++; $display("FAIL release got d%b h%b b%b w%b exp 1 0 0 0", done, cpu_hold, busy, wr_en); end
        n_checks++; if (wa.size() != 2 || wa[0] !== AW'(0) || wd[0] !== 32'h00000013 || wa[1] !== AW'(1) || wd[1] !== 32'h00100093) begin
            n_errors++; $display("FAIL basic_writes got n=%0d %h:%h %h:%h exp 2 00:00000013 01:00100093", wa.size(), wa[0], wd[0], wa[1], wd[1]);
        end
    endtask

    task automatic test_bad_len();
        wa.delete(); wd.delete();
        do_start();
        n_checks++; if (done !== 1'b0 || cpu_hold !== 1'b1) begin n_errors++; $display("FAIL reload_hold got d%b h%b exp 0 1", done, cpu_hold); end
        send_byte(8'h00); send_byte(8'h00);
        n_checks++; if (err !== 2'b01 || cpu_hold !== 1'b1 || busy !== 1'b0) begin n_errors++; $display("FAIL len_zero got e%b h%b b%b exp 01 1 0", err, cpu_hold, busy); end
        do_start();
        n_checks++; if (err !== 2'b00 || busy !== 1'b1) begin n_errors++; $display("FAIL err_clear got e%b b%b exp 00 1", err, busy); end
        send_byte(8'h1F); send_byte(8'h00);
        n_checks++; if (err !== 2'b01 || cpu_hold !== 1'b1) begin n_errors++; $display("FAIL len_over got e%b h%b exp 01 1", err, cpu_hold); end
        @(negedge clk);
        n_checks++; if (wa.size() != 0 || err !== 2'b01) begin n_errors++; $display("FAIL len_nowrite got n=%0d e%b exp 0 01", wa.size(), err); end
    endtask

    task automatic test_timeout();
        int k;
        wa.delete(); wd.delete();
        do_start();
        repeat (TO) @(negedge clk);
        send_byte(8'h01);
        n_checks++; if (err !== 2'b00 || busy !== 1'b1) begin n_errors++; $display("FAIL byte_wins got e%b b%b exp 00 1", err, busy); end
        send_byte(8'h00); send_byte(8'h13); send_byte(8'h00);
        k = 0;
        while (err === 2'b00 && k < TO + 20) begin
            @(negedge clk);
            k++;
        end
        n_checks++; if (k != TO + 1) begin n_errors++; $display("FAIL to_latency got %0d exp %0d", k, TO + 1); end
        n_checks++; if (err !== 2'b10 || cpu_hold !== 1'b1 || busy !== 1'b0) begin n_errors++; $display("FAIL to_state got e%b h%b b%b exp 10 1 0", err, cpu_hold, busy); end
        n_checks++; if (wa.size() != 0) begin n_errors++; $display("FAIL to_nowrite got %0d exp 0", wa.size()); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_w;
        wa.delete(); wd.delete();
        send_byte(8'h01); send_byte(8'h00); send_byte(8'h55); send_byte(8'h66);
        @(negedge clk);
        n_checks++; if (wa.size() != 0 || err !== 2'b10) begin n_errors++; $display("FAIL err_ignore got n=%0d e%b exp 0 10", wa.size(), err); end
        do_start();
        send_byte(8'(DEPTH)); send_byte(8'h00);
        for (int w = 0; w < DEPTH; w++)
            for (int b = 0; b < 4; b++) send_byte(8'(w * 4 + b));
        n_checks++; if (wr_en !== 1'b1 || wr_addr !== AW'(DEPTH - 1)) begin n_errors++; $display("FAIL b2b_last got %b %0d exp 1 %0d", wr_en, wr_addr, DEPTH - 1); end
        @(negedge clk);
        n_checks++; if (done !== 1'b1 || wa.size() != DEPTH) begin n_errors++; $display("FAIL b2b_done got d%b n=%0d exp 1 %0d", done, wa.size(), DEPTH); end
        for (int w = 0; w < DEPTH; w++) begin
            exp_w = {8'(w * 4 + 3), 8'(w * 4 + 2), 8'(w * 4 + 1), 8'(w * 4)};
            n_checks++; if (wa[w] !== AW'(w) || wd[w] !== exp_w) begin n_errors++; $display("FAIL b2b_word%0d got %h:%h exp %h:%h", w, wa[w], wd[w], AW'(w), exp_w); end
        end
        send_byte(8'h01); send_byte(8'h00); send_byte(8'h13); send_byte(8'h00);
        @(negedge clk);
        n_checks++; if (wa.size() != DEPTH || done !== 1'b1) begin n_errors++; $display("FAIL done_ignore got n=%0d d%b exp %0d 1", wa.size(), done, DEPTH); end
    endtask

    task automatic test_rst_mid();
        do_start();
        send_byte(8'h05); send_byte(8'h00);
        for (int i = 0; i < 10; i++) send_byte(8'hA0 + 8'(i));
        rst = 1'b1;
        @(negedge clk);
        n_checks++; if (cpu_hold !== 1'b1 || wr_en !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || err !== 2'b00) begin
            n_errors++; $display("FAIL midrst_ctl got h%b w%b b%b d%b e%b exp 1 0 0 0 00", cpu_hold, wr_en, busy, done, err);
        end
        n_checks++; if (wr_addr !== '0 || wr_data !== 32'h0) begin n_errors++; $display("FAIL midrst_wr got %h/%h exp 0/0", wr_addr, wr_data); end
        rst = 1'b0;
        @(negedge clk);
        wa.delete(); wd.delete();
        do_start();
        send_byte(8'h01); send_byte(8'h00);
        send_byte(8'hEF); send_byte(8'hBE); send_byte(8'hAD); send_byte(8'hDE);
        n_checks++; if (wr_en !== 1'b1 || wr_addr !== '0 || wr_data !== 32'hDEADBEEF) begin n_errors++; $display("FAIL reload_write got %b %h %h exp 1 00 deadbeef", wr_en, wr_addr, wr_data); end
        @(negedge clk);
        n_checks++; if (done !== 1'b1 || cpu_hold !== 1'b0 || wa.size() != 1) begin n_errors++; $display("FAIL reload_done got d%b h%b n=%0d exp 1 0 1", done, cpu_hold, wa.size()); end
    endtask

`ifdef IMEM_LOADER_CSUM_EN
    task automatic test_csum();
        wa.delete(); wd.delete();
        do_start();
        send_byte(8'h01); send_byte(8'h00);
        send_byte(8'h13); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        n_checks++; if (busy !== 1'b1 || done !== 1'b0) begin n_errors++; $display("FAIL csum_wait got b%b d%b exp 1 0", busy, done); end
        send_byte(8'h13);
        n_checks++; if (done !== 1'b0) begin n_errors++; $display("FAIL csum_fin got d%b exp 0", done); end
        @(negedge clk);
        n_checks++; if (done !== 1'b1 || cpu_hold !== 1'b0 || err !== 2'b00) begin n_errors++; $display("FAIL csum_ok got d%b h%b e%b exp 1 0 00", done, cpu_hold, err); end
        wa.delete(); wd.delete();
        do_start();
        send_byte(8'h01); send_byte(8'h00);
        send_byte(8'h13); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        send_byte(8'h14);
        n_checks++; if (err !== 2'b11 || cpu_hold !== 1'b1 || done !== 1'b0) begin n_errors++; $display("FAIL csum_bad got e%b h%b d%b exp 11 1 0", err, cpu_hold, done); end
        n_checks++; if (wa.size() != 1 || wd[0] !== 32'h00000013) begin n_errors++; $display("FAIL csum_bad_write got n=%0d %h exp 1 00000013", wa.size(), wd[0]); end
    endtask
`endif

    initial begin
        rst = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        repeat (2) @(negedge clk);
        test_reset();
        test_basic();
        test_bad_len();
        test_timeout();
        test_back_to_back();
        test_rst_mid();
`ifdef IMEM_LOADER_CSUM_EN
        test_csum();
`endif
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
